// File: rtl/cnn_pkg.sv
// Shared constants and types for the CNN scan loader.
//   ADDR_W   : address bits per scan frame
//   DATA_W   : data bits per scan frame (nine 8-bit weights)
//   FRAME_W  : total serial frame length, address first, MSB first
//   CNT_W    : width of the in-frame bit counter
//   loader_state_e : loader FSM states
package cnn_pkg;
  localparam int ADDR_W  = 10;
  localparam int DATA_W  = 72;
  localparam int FRAME_W = ADDR_W + DATA_W;
  localparam int CNT_W   = $clog2(FRAME_W);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } loader_state_e;
endpackage

// File: rtl/cnn_scan_loader_if.sv
// Bus between the scan host and the loader, plus the CNN-facing write port.
//   scan_en/scan_in : serial stream; a bit is taken on every clock with scan_en=1
//   start_i         : start request from the host
//   write_en/addr_w/data_w : one-cycle write strobe with held address/data
//   load_done       : level, full parameter image written
//   frame_err       : one-cycle pulse, partial frame discarded
//   sta             : one-cycle start pulse to the CNN
//   dbg_state       : loader FSM state for observation
// Handshake: the stream has no back-pressure; scan_en=1 means scan_in is valid
// this cycle and is always consumed (unless the load is DONE). write_en is a
// single-cycle strobe with no ready; addr_w/data_w are valid while it is high.
interface cnn_scan_loader_if;
  import cnn_pkg::*;

  logic                scan_en;
  logic                scan_in;
  logic                start_i;
  logic                write_en;
  logic [ADDR_W-1:0]   addr_w;
  logic [DATA_W-1:0]   data_w;
  logic                load_done;
  logic                frame_err;
  logic                sta;
  loader_state_e       dbg_state;

  modport master (
    output scan_en, scan_in, start_i,
    input  write_en, addr_w, data_w, load_done, frame_err, sta, dbg_state
  );

  modport slave (
    input  scan_en, scan_in, start_i,
    output write_en, addr_w, data_w, load_done, frame_err, sta, dbg_state
  );
endinterface

// File: rtl/scan_deser.sv
// Serial-to-parallel shift register with an in-frame bit counter.
//   clk, rst_n      : clock, asynchronous active-low reset
//   i_shift         : take i_scan_in this cycle
//   i_clear         : discard the partial frame (bit counter to 0)
//   i_scan_in       : serial bit, entered at the LSB
//   o_frame_full    : registered one-cycle flag, o_frame holds a complete frame
//   o_frame         : shift register contents
//   o_bit_cnt       : bits taken so far in the current frame
module scan_deser
  import cnn_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_shift,
  input  logic               i_clear,
  input  logic               i_scan_in,
  output logic               o_frame_full,
  output logic [FRAME_W-1:0] o_frame,
  output logic [CNT_W-1:0]   o_bit_cnt
);
  logic [FRAME_W-1:0] r_sr;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_full;
  logic               w_last;

  // The bit being taken now is the last of the frame.
  assign w_last = i_shift && (r_cnt == CNT_W'(FRAME_W - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sr   <= '0;
      r_cnt  <= '0;
      r_full <= 1'b0;
    end else begin
      r_full <= w_last;
      if (i_shift) r_sr <= {r_sr[FRAME_W-2:0], i_scan_in};
      if (i_clear || w_last) r_cnt <= '0;
      else if (i_shift)      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_frame_full = r_full;
  assign o_frame      = r_sr;
  assign o_bit_cnt    = r_cnt;
endmodule

// File: rtl/cnn_scan_loader.sv
// Weight/bias scan loader in front of the CNN. Deserialises 82-bit frames,
// writes them to the CNN scan port, counts frames to WORD_NUM, then gates
// host start requests into the CNN sta pulse.
//   WORD_NUM : frames in a complete load (1..2**ADDR_W)
//   clk      : clock
//   rst_n    : asynchronous active-low reset
//   bus      : cnn_scan_loader_if.slave (scan stream in, CNN write port out)
module cnn_scan_loader
  import cnn_pkg::*;
#(
  parameter int WORD_NUM = 128
) (
  input  logic               clk,
  input  logic               rst_n,
  cnn_scan_loader_if.slave   bus
);
  localparam int WC_W = $clog2(WORD_NUM + 1);

  loader_state_e       r_state, w_state_nxt;
  logic [WC_W-1:0]     r_word_cnt, w_word_cnt_nxt;
  logic                r_write_en, w_write_en_nxt;
  logic [ADDR_W-1:0]   r_addr_w, w_addr_w_nxt;
  logic [DATA_W-1:0]   r_data_w, w_data_w_nxt;
  logic                r_load_done, w_load_done_nxt;
  logic                r_frame_err, w_frame_err_nxt;
  logic                r_sta, w_sta_nxt;

  logic                w_shift;
  logic                w_abort;
  logic                w_last_word;
  logic                w_frame_full;
  logic [FRAME_W-1:0]  w_frame;
  logic [CNT_W-1:0]    w_bit_cnt;

  // The final frame is written in the same cycle the FSM enters DONE, so a
  // bit arriving in that cycle already belongs to the ignored region.
  assign w_last_word = w_frame_full && (r_word_cnt == WC_W'(WORD_NUM - 1));
  assign w_shift     = bus.scan_en && (r_state != DONE) && !w_last_word;
  // Right after a frame completes the FSM is still in SHIFT with bit_cnt=0;
  // a gap there is a normal inter-frame idle, not an abort.
  assign w_abort     = (r_state == SHIFT) && !bus.scan_en && (w_bit_cnt != '0);

  scan_deser u_deser (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_shift      (w_shift),
    .i_clear      (w_abort),
    .i_scan_in    (bus.scan_in),
    .o_frame_full (w_frame_full),
    .o_frame      (w_frame),
    .o_bit_cnt    (w_bit_cnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_word_cnt  <= '0;
      r_write_en  <= 1'b0;
      r_addr_w    <= '0;
      r_data_w    <= '0;
      r_load_done <= 1'b0;
      r_frame_err <= 1'b0;
      r_sta       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_word_cnt  <= w_word_cnt_nxt;
      r_write_en  <= w_write_en_nxt;
      r_addr_w    <= w_addr_w_nxt;
      r_data_w    <= w_data_w_nxt;
      r_load_done <= w_load_done_nxt;
      r_frame_err <= w_frame_err_nxt;
      r_sta       <= w_sta_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_word_cnt_nxt  = r_word_cnt;
    w_write_en_nxt  = w_frame_full;
    w_addr_w_nxt    = r_addr_w;
    w_data_w_nxt    = r_data_w;
    w_load_done_nxt = r_load_done || w_last_word;
    w_frame_err_nxt = w_abort;
    w_sta_nxt       = (r_state == DONE) && bus.start_i;

    if (w_frame_full) begin
      w_addr_w_nxt   = w_frame[FRAME_W-1:DATA_W];
      w_data_w_nxt   = w_frame[DATA_W-1:0];
      w_word_cnt_nxt = r_word_cnt + 1'b1;
    end

    case (r_state)
      IDLE: begin
        if (w_shift) w_state_nxt = SHIFT;
      end
      SHIFT: begin
        if (w_abort)            w_state_nxt = IDLE;
        else if (w_last_word)   w_state_nxt = DONE;
        else if (w_frame_full)  w_state_nxt = w_shift ? SHIFT : IDLE;
      end
      DONE:    w_state_nxt = DONE;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign bus.write_en  = r_write_en;
  assign bus.addr_w    = r_addr_w;
  assign bus.data_w    = r_data_w;
  assign bus.load_done = r_load_done;
  assign bus.frame_err = r_frame_err;
  assign bus.sta       = r_sta;
  assign bus.dbg_state = r_state;
endmodule
